// File: rtl/gate_pkg.sv
// ---------------------------------------------------------------------------
// gate_pkg : gate codes, truth-table constants and FSM state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gate_pkg;

  localparam logic [2:0] GATE_AND     = 3'd0;
  localparam logic [2:0] GATE_OR      = 3'd1;
  localparam logic [2:0] GATE_NOTA    = 3'd2;
  localparam logic [2:0] GATE_NAND    = 3'd3;
  localparam logic [2:0] GATE_NOR     = 3'd4;
  localparam logic [2:0] GATE_XOR     = 3'd5;
  localparam logic [2:0] GATE_XNOR    = 3'd6;
  localparam logic [2:0] GATE_UNKNOWN = 3'd7;

  // Bit i is the gate output for {a,b} = i, so bit 3 is vector 11.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOTA = 4'b0011;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gate_decode.sv
// ---------------------------------------------------------------------------
// gate_decode : maps a 4-bit truth table onto a 3-bit gate code
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_decode
  import gate_pkg::*;
(
  input  logic [3:0] truth_i,
  output logic [2:0] code_o
);

  always_comb begin
    code_o = GATE_UNKNOWN;
    case (truth_i)
      TT_AND:  code_o = GATE_AND;
      TT_OR:   code_o = GATE_OR;
      TT_NOTA: code_o = GATE_NOTA;
      TT_NAND: code_o = GATE_NAND;
      TT_NOR:  code_o = GATE_NOR;
      TT_XOR:  code_o = GATE_XOR;
      TT_XNOR: code_o = GATE_XNOR;
      default: code_o = GATE_UNKNOWN;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_identifier.sv
// ---------------------------------------------------------------------------
// gate_identifier : sweeps a/b over all four vectors, captures y, decodes gate
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_identifier
  import gate_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code
);

  localparam int             CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]  SETTLE_C = CW'(SETTLE);

  state_e        state_q;
  logic [1:0]    vec_q;
  logic [CW-1:0] cnt_q;
  logic          a_q, b_q, busy_q, done_q;
  logic [3:0]    truth_q;
  logic [2:0]    code_q;

  // The last sample is not yet in truth_q, so decode it in alongside the rest.
  logic [3:0]    truth_d;
  logic [2:0]    code_d;

  assign truth_d = {y, truth_q[2:0]};

  gate_decode u_decode (
    .truth_i (truth_d),
    .code_o  (code_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= 4'b0000;
      code_q  <= GATE_UNKNOWN;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            vec_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_q != SETTLE_C) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            truth_q[vec_q] <= y;
            cnt_q          <= '0;
            if (vec_q != 2'd3) begin
              vec_q      <= vec_q + 2'd1;
              {a_q, b_q} <= vec_q + 2'd1;
            end else begin
              state_q <= ST_IDLE;
              vec_q   <= 2'd0;
              busy_q  <= 1'b0;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              done_q  <= 1'b1;
              code_q  <= code_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truth     = truth_q;
  assign gate_code = code_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_identifier.sv
// ---------------------------------------------------------------------------
// tb_gate_identifier : three identifiers (SETTLE 1/3/0) driving modelled gates
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_identifier;

  typedef struct packed {
    logic [3:0] truth;
    logic [2:0] code;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  int         sel [3];
  wire  [2:0] a_v, b_v, y_v, busy_v, done_v;
  wire  [3:0] truth_v [3];
  wire  [2:0] code_v  [3];

  int   vectors;
  int   miscompares;
  exp_t sb [$];

  // Gate selector: 0..6 are the known gates, 7 ties y high, 8 ties y low.
  function automatic logic gf(input int g, input logic a, input logic b);
    case (g)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      6: return ~(a ^ b);
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t expect_for(input int g);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v          = 2'(i);
      e.truth[i] = gf(g, v[1], v[0]);
    end
    e.code = (g <= 6) ? 3'(g) : 3'd7;
    return e;
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  assign y_v[0] = gf(sel[0], a_v[0], b_v[0]);
  assign y_v[1] = gf(sel[1], a_v[1], b_v[1]);
  assign y_v[2] = gf(sel[2], a_v[2], b_v[2]);

  gate_identifier #(.SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .y(y_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .truth(truth_v[0]), .gate_code(code_v[0])
  );
  gate_identifier #(.SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .y(y_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .truth(truth_v[1]), .gate_code(code_v[1])
  );
  gate_identifier #(.SETTLE(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .y(y_v[2]), .a(a_v[2]), .b(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .truth(truth_v[2]), .gate_code(code_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller has raised start at the current negedge. Counts negedges until done,
  // checking busy and the driven vector on every cycle of the run.
  task automatic wait_done(input int d, input int pulse_at, input bit hold);
    int   cyc;
    bit   seen;
    int   s;
    exp_t e;
    cyc  = 0;
    seen = 0;
    s    = settle_of(d);
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold) start_v[d] = (cyc == pulse_at);
      if (done_v[d]) begin
        seen = 1;
      end else begin
        chk("busy_in_run", int'(busy_v[d]), 1);
        chk("ab_vector", int'({a_v[d], b_v[d]}), ((cyc - 1) / (s + 1)) % 4);
      end
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("latency", cyc, 4 * (s + 1) + 1);
      chk("busy_at_done", int'(busy_v[d]), 0);
      chk("ab_at_done", int'({a_v[d], b_v[d]}), 0);
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("truth", int'(truth_v[d]), int'(e.truth));
        chk("gate_code", int'(code_v[d]), int'(e.code));
      end
    end
  endtask

  task automatic run(input int d, input int g, input int pulse_at);
    @(negedge clk);
    sel[d]     = g;
    start_v[d] = 1'b1;
    sb.push_back(expect_for(g));
    wait_done(d, pulse_at, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", int'(done_v[d]), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start_v     = 3'b000;
    sel[0]      = 0;
    sel[1]      = 0;
    sel[2]      = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_a", int'(a_v[0]), 0);
    chk("rst_b", int'(b_v[0]), 0);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_done", int'(done_v[0]), 0);
    chk("rst_truth", int'(truth_v[0]), 0);
    chk("rst_code", int'(code_v[0]), 7);

    for (int g = 0; g <= 8; g++) run(0, g, 0);

    // A start pulse during the run must be ignored.
    run(0, 5, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_rerun_busy", int'(busy_v[0]), 0);
      chk("no_rerun_done", int'(done_v[0]), 0);
    end

    // Reset while vector 2 is being driven aborts the run.
    @(negedge clk);
    sel[0]     = 0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_vec", int'({a_v[0], b_v[0]}), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_ab", int'({a_v[0], b_v[0]}), 0);
    chk("abort_truth", int'(truth_v[0]), 0);
    chk("abort_code", int'(code_v[0]), 7);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done_v[0]), 0);
    end

    run(1, 5, 0);

    // Start held high through done gives back-to-back runs.
    @(negedge clk);
    sel[1]     = 5;
    start_v[1] = 1'b1;
    sb.push_back(expect_for(5));
    sb.push_back(expect_for(5));
    wait_done(1, 0, 1'b1);
    wait_done(1, 0, 1'b1);
    start_v[1] = 1'b0;
    @(negedge clk);
    chk("b2b_done_drop", int'(done_v[1]), 0);
    chk("b2b_idle", int'(busy_v[1]), 0);

    run(2, 4, 0);
    run(2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
